// File: rtl/io_clock_pkg.sv
// Shared definitions for the Amiga timing-enable sequencer.
// The package holds the E-clock phase constants, the E-phase type, and
// a helper function that sizes the master-clock prescaler.
package io_clock_pkg;

    // Number of 7 MHz ticks in one CIA E-clock period.
    localparam int E_PHASES     = 10;
    // First E-phase in which ECLK is high (6 low phases, then 4 high phases).
    localparam int E_HIGH_START = 6;

    typedef logic [3:0] e_phase_t;

    localparam e_phase_t E_LAST = e_phase_t'(E_PHASES - 1);
    localparam e_phase_t E_HIGH = e_phase_t'(E_HIGH_START);

    // Bits needed to count 0..div-1. The counter keeps at least one bit,
    // so that DIV=1 still has a well-formed (always zero) register.
    function automatic int prescaler_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/io_clock_prescaler.sv
// Master-clock prescaler for the timing-enable sequencer.
// Counts 0..DIV-1 while RUN is high and holds its value while RUN is low.
// Ports:
//   CLK     in  master clock, rising edge
//   RESET_N in  synchronous active-low reset
//   RUN     in  1 = count advances, 0 = count frozen
//   RESYNC  in  synchronous restart of the count
//   tick    out high in a cycle whose rising edge is a 7 MHz tick
module io_clock_prescaler
    import io_clock_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic RUN,
    input  logic RESYNC,
    output logic tick
);

    localparam int             W    = prescaler_width(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // The tick is decoded from the registered count and RUN only. The
    // sequencer registers every output on it, so no input reaches an output
    // without passing through a flop. With DIV=1, LAST is 0 and the tick
    // follows RUN.
    assign tick = RUN && (cnt_q == LAST);

    // NOTE: every signal written in always_comb gets a default first.
    // Otherwise a path that skips the assignment infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (RUN) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge CLK) begin
        if (!RESET_N || RESYNC) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_clock_sequencer.sv
// Amiga timing-enable sequencer. It derives, from the master CLK, the 7 MHz
// enable, the colour clock (CCK), and the CIA E-clock (1/10 of 7 MHz,
// 6 phases low and 4 phases high). Downstream blocks gate their logic on
// these enables. All outputs are registered.
// Ports:
//   CLK        in  master clock, rising edge
//   RESET_N    in  synchronous active-low reset
//   RUN        in  1 = advance, 0 = freeze (levels hold, pulses drop)
//   RESYNC     in  synchronous phase restart (same register effect as reset)
//   C7M_EN     out one-cycle pulse per 7 MHz tick
//   CCK        out colour-clock level, toggles on each tick
//   CCK_RISE   out pulse in the first cycle in which CCK reads 1
//   CCK_FALL   out pulse in the first cycle in which CCK reads 0
//   ECLK       out E-clock level
//   ECLK_RISE  out pulse in the first cycle in which ECLK reads 1
//   ECLK_FALL  out pulse in the first cycle in which ECLK reads 0 (9->0 wrap only)
//   E_PHASE    out current E-phase, 0..9
module io_clock_sequencer
    import io_clock_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       RUN,
    input  logic       RESYNC,
    output logic       C7M_EN,
    output logic       CCK,
    output logic       CCK_RISE,
    output logic       CCK_FALL,
    output logic       ECLK,
    output logic       ECLK_RISE,
    output logic       ECLK_FALL,
    output logic [3:0] E_PHASE
);

    logic tick;

    io_clock_prescaler #(.DIV(DIV)) u_prescaler (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .RUN     (RUN),
        .RESYNC  (RESYNC),
        .tick    (tick)
    );

    logic     c7m_en_q,    c7m_en_d;
    logic     cck_q,       cck_d;
    logic     cck_rise_q,  cck_rise_d;
    logic     cck_fall_q,  cck_fall_d;
    logic     eclk_q,      eclk_d;
    logic     eclk_rise_q, eclk_rise_d;
    logic     eclk_fall_q, eclk_fall_d;
    e_phase_t e_phase_q,   e_phase_d;
    e_phase_t e_phase_next;

    assign e_phase_next = (e_phase_q == E_LAST) ? '0 : e_phase_q + 4'd1;

    // On a tick, the E-clock level and its edge pulses are decoded from the
    // phase being entered. They therefore line up with E_PHASE in the same
    // cycle. On a non-tick edge, levels hold and pulses drop.
    always_comb begin
        c7m_en_d    = 1'b0;
        cck_d       = cck_q;
        cck_rise_d  = 1'b0;
        cck_fall_d  = 1'b0;
        eclk_d      = eclk_q;
        eclk_rise_d = 1'b0;
        eclk_fall_d = 1'b0;
        e_phase_d   = e_phase_q;
        if (tick) begin
            c7m_en_d    = 1'b1;
            cck_d       = ~cck_q;
            cck_rise_d  = ~cck_q;
            cck_fall_d  = cck_q;
            e_phase_d   = e_phase_next;
            eclk_d      = (e_phase_next >= E_HIGH);
            eclk_rise_d = (e_phase_next == E_HIGH);
            eclk_fall_d = (e_phase_next == '0);
        end
    end

    // RESYNC has the same effect as reset and overrides a coincident tick.
    // The clearing branch never raises ECLK_FALL, so the partial E period is
    // dropped silently.
    always_ff @(posedge CLK) begin
        if (!RESET_N || RESYNC) begin
            c7m_en_q    <= 1'b0;
            cck_q       <= 1'b0;
            cck_rise_q  <= 1'b0;
            cck_fall_q  <= 1'b0;
            eclk_q      <= 1'b0;
            eclk_rise_q <= 1'b0;
            eclk_fall_q <= 1'b0;
            e_phase_q   <= '0;
        end else begin
            c7m_en_q    <= c7m_en_d;
            cck_q       <= cck_d;
            cck_rise_q  <= cck_rise_d;
            cck_fall_q  <= cck_fall_d;
            eclk_q      <= eclk_d;
            eclk_rise_q <= eclk_rise_d;
            eclk_fall_q <= eclk_fall_d;
            e_phase_q   <= e_phase_d;
        end
    end

    assign C7M_EN    = c7m_en_q;
    assign CCK       = cck_q;
    assign CCK_RISE  = cck_rise_q;
    assign CCK_FALL  = cck_fall_q;
    assign ECLK      = eclk_q;
    assign ECLK_RISE = eclk_rise_q;
    assign ECLK_FALL = eclk_fall_q;
    assign E_PHASE   = e_phase_q;

endmodule

// File: tb/tb_io_clock_sequencer.sv
// Bench for io_clock_sequencer. Two instances share one set of inputs:
// inst 0 uses DIV=4 and inst 1 uses DIV=1. A reference model counts
// prescaler cycles and ticks since the last restart. It derives every
// expected output from the tick count with plain arithmetic.
module tb_io_clock_sequencer;

    logic clk = 1'b0;
    logic rst_n, run, resync;

    logic       a_c7m, a_cck, a_cr, a_cf, a_e, a_er, a_ef;
    logic [3:0] a_ph;
    logic       b_c7m, b_cck, b_cr, b_cf, b_e, b_er, b_ef;
    logic [3:0] b_ph;

    int checks   = 0;
    int failures = 0;

    // Reference model state, indexed by instance.
    int div_m [2] = '{4, 1};
    int pre_m [2];
    int ntk_m [2];
    bit tk_m  [2];

    always #5 clk = ~clk;

    io_clock_sequencer #(.DIV(4)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .RUN(run), .RESYNC(resync),
        .C7M_EN(a_c7m), .CCK(a_cck), .CCK_RISE(a_cr), .CCK_FALL(a_cf),
        .ECLK(a_e), .ECLK_RISE(a_er), .ECLK_FALL(a_ef), .E_PHASE(a_ph)
    );

    io_clock_sequencer #(.DIV(1)) dut_b (
        .CLK(clk), .RESET_N(rst_n), .RUN(run), .RESYNC(resync),
        .C7M_EN(b_c7m), .CCK(b_cck), .CCK_RISE(b_cr), .CCK_FALL(b_cf),
        .ECLK(b_e), .ECLK_RISE(b_er), .ECLK_FALL(b_ef), .E_PHASE(b_ph)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic c7m, input logic cck, input logic cr,
                              input logic cf, input logic e, input logic er, input logic ef,
                              input logic [3:0] ph);
        string nm;
        int    p;
        nm = (k == 0) ? "div4" : "div1";
        p  = ntk_m[k] % 10;
        check({nm, ".c7m_en"},    {3'b0, c7m}, {3'b0, tk_m[k]});
        check({nm, ".cck"},       {3'b0, cck}, 4'(ntk_m[k] % 2));
        check({nm, ".cck_rise"},  {3'b0, cr},  {3'b0, tk_m[k] && (ntk_m[k] % 2 == 1)});
        check({nm, ".cck_fall"},  {3'b0, cf},  {3'b0, tk_m[k] && (ntk_m[k] % 2 == 0)});
        check({nm, ".e_phase"},   ph,          4'(p));
        check({nm, ".eclk"},      {3'b0, e},   {3'b0, p >= 6});
        check({nm, ".eclk_rise"}, {3'b0, er},  {3'b0, tk_m[k] && p == 6});
        check({nm, ".eclk_fall"}, {3'b0, ef},  {3'b0, tk_m[k] && p == 0});
    endtask

    // One clock edge. Drive the inputs, advance the model, then sample
    // 1 time unit after the edge and compare both instances.
    task automatic step(input logic r_n, input logic rn, input logic rs);
        rst_n  = r_n;
        run    = rn;
        resync = rs;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            tk_m[k] = 1'b0;
            if (!r_n || rs) begin
                pre_m[k] = 0;
                ntk_m[k] = 0;
            end else if (rn) begin
                if (pre_m[k] == div_m[k] - 1) begin
                    pre_m[k] = 0;
                    ntk_m[k] = ntk_m[k] + 1;
                    tk_m[k]  = 1'b1;
                end else begin
                    pre_m[k] = pre_m[k] + 1;
                end
            end
        end
        #1;
        check_inst(0, a_c7m, a_cck, a_cr, a_cf, a_e, a_er, a_ef, a_ph);
        check_inst(1, b_c7m, b_cck, b_cr, b_cf, b_e, b_er, b_ef, b_ph);
    endtask

    initial begin
        int meas_a, per_a, hi_a, meas_b, per_b, hi_b, c7m_b_lo;

        rst_n = 1'b0; run = 1'b1; resync = 1'b0;

        // Reset state.
        step(0, 1, 0);
        step(0, 1, 0);
        check("reset.c7m_en", {3'b0, a_c7m}, 4'd0);
        check("reset.e_phase", a_ph, 4'd0);

        // Release with RUN=1: the first C7M_EN comes at the 4th edge.
        step(1, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        check("release.no_early_tick", {3'b0, a_c7m}, 4'd0);
        step(1, 1, 0);
        check("release.first_c7m", {3'b0, a_c7m}, 4'd1);
        check("release.cck_rise", {3'b0, a_cr}, 4'd1);

        // Run 60 ticks. Measure one ECLK period on each instance.
        meas_a = 0; per_a = 0; hi_a = 0;
        meas_b = 0; per_b = 0; hi_b = 0; c7m_b_lo = 0;
        for (int i = 0; i < 236; i++) begin
            step(1, 1, 0);
            if (a_er) begin
                if (meas_a == 1) meas_a = 2;
                else if (meas_a == 0) meas_a = 1;
            end
            if (meas_a == 1) begin per_a++; hi_a += int'(a_e); end
            if (b_er) begin
                if (meas_b == 1) meas_b = 2;
                else if (meas_b == 0) meas_b = 1;
            end
            if (meas_b == 1) begin per_b++; hi_b += int'(b_e); end
            if (!b_c7m) c7m_b_lo++;
        end
        check("div4.eclk_period", 4'(per_a / 4), 4'd10);
        check("div4.eclk_high", 4'(hi_a / 4), 4'd4);
        check("div1.eclk_period", 4'(per_b), 4'd10);
        check("div1.eclk_high", 4'(hi_b), 4'd4);
        check("div1.c7m_constant", 4'(c7m_b_lo), 4'd0);

        // Freeze with the prescaler at 2. The next tick comes 2 cycles after RUN returns.
        step(0, 1, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        step(1, 1, 0);
        check("resume.no_tick_yet", {3'b0, a_c7m}, 4'd0);
        step(1, 1, 0);
        check("resume.tick", {3'b0, a_c7m}, 4'd1);

        // RESYNC coincides with a due tick at E_PHASE=8.
        step(0, 1, 0);
        for (int i = 0; i < 35; i++) step(1, 1, 0);
        check("resync.pre_phase", a_ph, 4'd8);
        step(1, 1, 1);
        check("resync.no_c7m", {3'b0, a_c7m}, 4'd0);
        check("resync.phase", a_ph, 4'd0);
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        check("resync.next_tick", {3'b0, a_c7m}, 4'd1);
        check("resync.next_phase", a_ph, 4'd1);

        // Reset while ECLK is high: ECLK clears without an ECLK_FALL pulse.
        step(0, 1, 0);
        for (int i = 0; i < 28; i++) step(1, 1, 0);
        check("rst_eclk.pre_high", {3'b0, a_e}, 4'd1);
        step(0, 1, 0);
        check("rst_eclk.eclk", {3'b0, a_e}, 4'd0);
        check("rst_eclk.no_fall", {3'b0, a_ef}, 4'd0);
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        check("rst_eclk.restart", {3'b0, a_c7m}, 4'd1);

        // Random RUN, RESYNC and RESET_N mix, checked against the model every edge.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
